// File: rtl/mdu_exe_unit.sv
// mdu_exe_unit: iterative multiply/divide execution unit.
// Shift-add multiply and restoring divide, one bit per cycle, on operand
// magnitudes with the result sign applied on the final iteration.
// Optional feature macro MDU_EARLY_OUT_EN: zero operands, divide-by-zero and
// signed divide overflow complete straight from accept without iterating.
module mdu_exe_unit #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 5
) (
    input  logic              i_aclk,
    input  logic              i_areset_n,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [2:0]        i_op,
    input  logic [DATA_W-1:0] i_op_a,
    input  logic [DATA_W-1:0] i_op_b,
    input  logic [TAG_W-1:0]  i_tag,
    input  logic              i_flush,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_result,
    output logic [TAG_W-1:0]  o_tag,
    output logic              o_busy
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DATA_W);

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [2:0]            r_op;
    logic [CNT_W-1:0]      r_cnt;
    logic [DATA_W-1:0]     r_mcand;
    logic [2*DATA_W-1:0]   r_prod;
    logic                  r_neg;
    logic                  r_rem_neg;
    logic                  r_div0;
    logic [DATA_W-1:0]     r_result;
    logic [TAG_W-1:0]      r_tag;

    logic                  w_accept;
    logic                  w_a_sign;
    logic                  w_b_sign;
    logic [DATA_W-1:0]     w_a_mag;
    logic [DATA_W-1:0]     w_b_mag;
    logic                  w_b_zero;
    logic                  w_early;
    logic [DATA_W-1:0]     w_early_result;
    logic [DATA_W:0]       w_sum;
    logic [DATA_W:0]       w_shift;
    logic [DATA_W:0]       w_diff;
    logic                  w_ge;
    logic [2*DATA_W-1:0]   w_step;
    logic [2*DATA_W-1:0]   w_prod_signed;
    logic [DATA_W-1:0]     w_final;

    assign w_accept = (r_state == S_IDLE) & i_valid & ~i_flush;

    // Operand decode: which operands are signed, and their magnitudes
    assign w_a_sign = i_op_a[DATA_W-1] & ((i_op == OP_MULH) | (i_op == OP_MULHSU) |
                                          (i_op == OP_DIV)  | (i_op == OP_REM));
    assign w_b_sign = i_op_b[DATA_W-1] & ((i_op == OP_MULH) | (i_op == OP_DIV) |
                                          (i_op == OP_REM));
    assign w_a_mag  = w_a_sign ? -i_op_a : i_op_a;
    assign w_b_mag  = w_b_sign ? -i_op_b : i_op_b;
    assign w_b_zero = (i_op_b == '0);

`ifdef MDU_EARLY_OUT_EN
    logic w_a_zero;
    logic w_div_ovf;
    assign w_a_zero  = (i_op_a == '0);
    assign w_div_ovf = i_op[2] & ~i_op[0] &
                       (i_op_a == {1'b1, {(DATA_W-1){1'b0}}}) & (&i_op_b);
    assign w_early   = w_a_zero | w_b_zero | w_div_ovf;

    // Direct results for the trivially-known cases; any other zero operand gives 0
    always_comb begin
        w_early_result = '0;
        if (i_op[2]) begin
            if (w_b_zero) begin
                w_early_result = i_op[1] ? i_op_a : '1;
            end else if (w_div_ovf) begin
                w_early_result = i_op[1] ? '0 : i_op_a;
            end
        end
    end
`else
    assign w_early        = 1'b0;
    assign w_early_result = '0;
`endif

    // One iteration: multiply adds the multiplicand into the high half and shifts
    // right; divide shifts the remainder/quotient pair left and trial-subtracts
    always_comb begin
        w_sum   = {1'b0, r_prod[2*DATA_W-1:DATA_W]} + (r_prod[0] ? {1'b0, r_mcand} : '0);
        w_shift = {r_prod[2*DATA_W-1:DATA_W], r_prod[DATA_W-1]};
        w_diff  = w_shift - {1'b0, r_mcand};
        w_ge    = ~w_diff[DATA_W];
        if (r_op[2]) begin
            w_step = {(w_ge ? w_diff[DATA_W-1:0] : w_shift[DATA_W-1:0]),
                      r_prod[DATA_W-2:0], w_ge};
        end else begin
            w_step = {w_sum, r_prod[DATA_W-1:1]};
        end
    end

    // Sign fix-up and result selection from the last iteration's value
    always_comb begin
        w_prod_signed = r_neg ? -w_step : w_step;
        case (r_op)
            OP_MUL:                      w_final = w_prod_signed[DATA_W-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: w_final = w_prod_signed[2*DATA_W-1:DATA_W];
            OP_DIV, OP_DIVU: begin
                if (r_div0) begin
                    w_final = '1;
                end else begin
                    w_final = r_neg ? -w_step[DATA_W-1:0] : w_step[DATA_W-1:0];
                end
            end
            default: w_final = r_rem_neg ? -w_step[2*DATA_W-1:DATA_W]
                                         : w_step[2*DATA_W-1:DATA_W];
        endcase
    end

    // State register
    always_ff @(posedge i_aclk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state: flush wins over both accept and output handshake
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_next = w_early ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                if (i_flush) begin
                    w_state_next = S_IDLE;
                end else if (r_cnt == CNT_ONE) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (i_flush || i_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Datapath: capture on accept, iterate in CALC, register the result on the last step
    always_ff @(posedge i_aclk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            r_op      <= '0;
            r_cnt     <= '0;
            r_mcand   <= '0;
            r_prod    <= '0;
            r_neg     <= 1'b0;
            r_rem_neg <= 1'b0;
            r_div0    <= 1'b0;
            r_result  <= '0;
            r_tag     <= '0;
        end else if (w_accept) begin
            r_op      <= i_op;
            r_tag     <= i_tag;
            r_cnt     <= CNT_LOAD;
            r_neg     <= w_a_sign ^ w_b_sign;
            r_rem_neg <= w_a_sign;
            r_div0    <= w_b_zero;
            if (i_op[2]) begin
                r_prod  <= {{DATA_W{1'b0}}, w_a_mag};
                r_mcand <= w_b_mag;
            end else begin
                r_prod  <= {{DATA_W{1'b0}}, w_b_mag};
                r_mcand <= w_a_mag;
            end
            if (w_early) begin
                r_result <= w_early_result;
            end
        end else if (r_state == S_CALC && !i_flush) begin
            r_prod <= w_step;
            r_cnt  <= r_cnt - CNT_ONE;
            if (r_cnt == CNT_ONE) begin
                r_result <= w_final;
            end
        end
    end

    assign o_ready  = (r_state == S_IDLE);
    assign o_valid  = (r_state == S_DONE);
    assign o_busy   = (r_state != S_IDLE);
    assign o_result = r_result;
    assign o_tag    = r_tag;

endmodule

// File: tb/tb_mdu_exe_unit.sv
// tb_mdu_exe_unit: scoreboard bench for mdu_exe_unit with directed vectors.
// Latency is counted in rising edges with the accept edge as edge 1.
module tb_mdu_exe_unit;

    localparam int DATA_W = 32;
    localparam int TAG_W  = 5;
    localparam int CALC_LAT = DATA_W + 1;
`ifdef MDU_EARLY_OUT_EN
    localparam int EARLY_LAT = 1;
`else
    localparam int EARLY_LAT = DATA_W + 1;
`endif

    logic              i_aclk;
    logic              i_areset_n;
    logic              i_valid;
    logic              o_ready;
    logic [2:0]        i_op;
    logic [DATA_W-1:0] i_op_a;
    logic [DATA_W-1:0] i_op_b;
    logic [TAG_W-1:0]  i_tag;
    logic              i_flush;
    logic              o_valid;
    logic              i_ready;
    logic [DATA_W-1:0] o_result;
    logic [TAG_W-1:0]  o_tag;
    logic              o_busy;

    typedef struct packed {
        logic [DATA_W-1:0] res;
        logic [TAG_W-1:0]  tag;
    } exp_t;

    exp_t  expQ[$];
    string nameQ[$];
    int    vectors = 0;
    int    fails   = 0;

    mdu_exe_unit #(.DATA_W(DATA_W), .TAG_W(TAG_W)) dut (
        .i_aclk     (i_aclk),
        .i_areset_n (i_areset_n),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_op       (i_op),
        .i_op_a     (i_op_a),
        .i_op_b     (i_op_b),
        .i_tag      (i_tag),
        .i_flush    (i_flush),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_result   (o_result),
        .o_tag      (o_tag),
        .o_busy     (o_busy)
    );

    // Free-running clock
    initial i_aclk = 1'b0;
    always #5 i_aclk = ~i_aclk;

    task automatic checkOutput(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Issue one request, check its latency, optional hold behaviour and return to idle
    task automatic applyStimulus(input string nm, input logic [2:0] op,
                                 input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                                 input logic [TAG_W-1:0] tag, input logic [DATA_W-1:0] expRes,
                                 input bit early, input int holdCycles);
        int edges;
        int lat;
        edges = 0;
        while (!o_ready && edges < 100) begin
            @(posedge i_aclk); #1;
            edges++;
        end
        if (!o_ready) begin
            checkOutput({nm, "_ready_timeout"}, 64'(o_ready), 64'd1);
            return;
        end
        if (holdCycles > 0) i_ready = 1'b0;
        i_valid = 1'b1;
        i_op    = op;
        i_op_a  = a;
        i_op_b  = b;
        i_tag   = tag;
        expQ.push_back('{res: expRes, tag: tag});
        nameQ.push_back(nm);
        @(posedge i_aclk); #1;
        i_valid = 1'b0;
        edges = 1;
        while (!o_valid && edges < 100) begin
            @(posedge i_aclk); #1;
            edges++;
        end
        lat = early ? EARLY_LAT : CALC_LAT;
        checkOutput({nm, "_latency"}, 64'(edges), 64'(lat));
        if (!o_valid) begin
            expQ.delete();
            nameQ.delete();
            i_flush = 1'b1;
            @(posedge i_aclk); #1;
            i_flush = 1'b0;
            i_ready = 1'b1;
            return;
        end
        for (int i = 0; i < holdCycles; i++) begin
            @(negedge i_aclk);
            checkOutput({nm, "_hold"}, 64'({o_valid, o_ready, o_result, o_tag}),
                        64'({1'b1, 1'b0, expRes, tag}));
        end
        if (holdCycles > 0) begin
            @(posedge i_aclk); #1;
            i_ready = 1'b1;
        end
        @(posedge i_aclk); #1;
        checkOutput({nm, "_idle"}, 64'(o_ready), 64'd1);
    endtask

    // Monitor: pop the scoreboard on every output handshake
    initial begin
        exp_t  e;
        string nm;
        forever begin
            @(negedge i_aclk);
            if (i_areset_n && o_valid && i_ready) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_output", 64'(o_result), 64'd0 - 64'd1);
                end else begin
                    e  = expQ.pop_front();
                    nm = nameQ.pop_front();
                    checkOutput({nm, "_result"}, 64'(o_result), 64'(e.res));
                    checkOutput({nm, "_tag"}, 64'(o_tag), 64'(e.tag));
                end
            end
        end
    end

    // Watchdog against a hung run
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed sequence
    initial begin
        int seen;
        i_areset_n = 1'b0;
        i_valid    = 1'b0;
        i_op       = '0;
        i_op_a     = '0;
        i_op_b     = '0;
        i_tag      = '0;
        i_flush    = 1'b0;
        i_ready    = 1'b1;
        repeat (3) @(posedge i_aclk);
        #1;
        checkOutput("reset_state", 64'({o_valid, o_ready, o_busy, o_result, o_tag}),
                    64'({1'b0, 1'b1, 1'b0, 32'h0, 5'h0}));
        i_areset_n = 1'b1;
        @(posedge i_aclk); #1;

        applyStimulus("mul_neg",     3'd0, 32'hFFFFFFFD, 32'd7,        5'd1,  32'hFFFFFFEB, 1'b0, 0);
        applyStimulus("mulh_min",    3'd1, 32'h80000000, 32'h80000000, 5'd2,  32'h40000000, 1'b0, 0);
        applyStimulus("mulh_neg",    3'd1, 32'hFFFFFFFD, 32'd7,        5'd3,  32'hFFFFFFFF, 1'b0, 0);
        applyStimulus("mulhsu",      3'd2, 32'hFFFFFFFF, 32'd2,        5'd4,  32'hFFFFFFFF, 1'b0, 0);
        applyStimulus("div_neg",     3'd4, 32'hFFFFFFF9, 32'd2,        5'd5,  32'hFFFFFFFD, 1'b0, 0);
        applyStimulus("rem_neg",     3'd6, 32'hFFFFFFF9, 32'd2,        5'd6,  32'hFFFFFFFF, 1'b0, 0);
        applyStimulus("divu",        3'd5, 32'd100,      32'd7,        5'd7,  32'd14,       1'b0, 0);
        applyStimulus("remu",        3'd7, 32'd100,      32'd7,        5'd8,  32'd2,        1'b0, 0);
        applyStimulus("div_negb",    3'd4, 32'd7,        32'hFFFFFFFE, 5'd9,  32'hFFFFFFFD, 1'b0, 0);
        applyStimulus("rem_negb",    3'd6, 32'd7,        32'hFFFFFFFE, 5'd10, 32'd1,        1'b0, 0);
        applyStimulus("div_by0",     3'd4, 32'd5,        32'd0,        5'd11, 32'hFFFFFFFF, 1'b1, 0);
        applyStimulus("rem_by0",     3'd6, 32'd5,        32'd0,        5'd12, 32'd5,        1'b1, 0);
        applyStimulus("remu_by0",    3'd7, 32'hFFFFFFF0, 32'd0,        5'd13, 32'hFFFFFFF0, 1'b1, 0);
        applyStimulus("div_ovf",     3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd14, 32'h80000000, 1'b1, 0);
        applyStimulus("rem_ovf",     3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd15, 32'd0,        1'b1, 0);
        applyStimulus("mul_zero",    3'd0, 32'd0,        32'd12345,    5'd16, 32'd0,        1'b1, 0);
        applyStimulus("mul_hold",    3'd0, 32'd6,        32'd7,        5'd31, 32'd42,       1'b0, 10);

        // Flush in the 12th CALC cycle must abandon the request
        i_valid = 1'b1;
        i_op    = 3'd0;
        i_op_a  = 32'd3;
        i_op_b  = 32'd5;
        i_tag   = 5'd17;
        @(posedge i_aclk); #1;
        i_valid = 1'b0;
        repeat (11) @(posedge i_aclk);
        #1;
        checkOutput("flush_pre_busy", 64'({o_valid, o_ready, o_busy}), 64'(3'b001));
        i_flush = 1'b1;
        @(posedge i_aclk); #1;
        i_flush = 1'b0;
        checkOutput("flush_idle", 64'({o_valid, o_ready, o_busy}), 64'(3'b010));
        seen = 0;
        repeat (40) begin
            @(posedge i_aclk); #1;
            if (o_valid) seen++;
        end
        checkOutput("flush_no_valid", 64'(seen), 64'd0);
        applyStimulus("mulhu_max",   3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd18, 32'hFFFFFFFE, 1'b0, 0);

        // Reset in the 5th CALC cycle discards the operation immediately
        i_valid = 1'b1;
        i_op    = 3'd0;
        i_op_a  = 32'd6;
        i_op_b  = 32'd7;
        i_tag   = 5'd9;
        @(posedge i_aclk); #1;
        i_valid = 1'b0;
        repeat (4) @(posedge i_aclk);
        #1;
        i_areset_n = 1'b0;
        #1;
        checkOutput("reset_mid", 64'({o_valid, o_ready, o_busy, o_result, o_tag}),
                    64'({1'b0, 1'b1, 1'b0, 32'h0, 5'h0}));
        repeat (2) @(posedge i_aclk);
        #1;
        i_areset_n = 1'b1;
        @(posedge i_aclk); #1;
        applyStimulus("divu_post_rst", 3'd5, 32'd9, 32'd3, 5'h15, 32'd3, 1'b0, 0);

        repeat (5) @(posedge i_aclk);
        #1;
        checkOutput("sb_drain", 64'(expQ.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule

// File: doc/mdu_exe_unit.md
MDU_EXE_UNIT -- requirements
Module: mdu_exe_unit

Interface
REQ-001 Parameter DATA_W, 32: operand and result width in bits; even and at least 8.
REQ-002 Parameter TAG_W, 5: width of the pass-through tag (destination register index).
REQ-003 Port i_aclk, input, 1: clock; every flop samples on its rising edge.
REQ-004 Port i_areset_n, input, 1: reset, asynchronous, active-low.
REQ-005 Port i_valid, input, 1: request valid.
REQ-006 Port o_ready, output, 1: block can accept a request.
REQ-007 Port i_op, input, 3: operation; 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-008 Port i_op_a, input, DATA_W: operand A (rs1).
REQ-009 Port i_op_b, input, DATA_W: operand B (rs2).
REQ-010 Port i_tag, input, TAG_W: tag, captured on accept.
REQ-011 Port i_flush, input, 1: abort any request in flight.
REQ-012 Port o_valid, output, 1: result valid.
REQ-013 Port i_ready, input, 1: downstream accepts the result.
REQ-014 Port o_result, output, DATA_W: result.
REQ-015 Port o_tag, output, TAG_W: tag captured on accept.
REQ-016 Port o_busy, output, 1: high in any state other than IDLE; drives the hazard-unit stall.

Function
REQ-017 The block SHALL implement three states: IDLE, CALC, DONE.
REQ-018 o_ready SHALL equal (state==IDLE); o_valid SHALL equal (state==DONE).
REQ-019 Accept condition: i_valid & o_ready & ~i_flush at a rising edge; on accept the block SHALL capture i_op, operand magnitudes, sign flags and i_tag, load an iteration counter with DATA_W, and enter CALC.
REQ-020 Iteration rate: one bit per cycle in CALC (shift-add multiply, restoring divide), with the counter decremented every cycle.
REQ-021 Exit: CALC SHALL exit to DONE on the edge where the counter equals 1, so o_valid rises DATA_W+1 edges after the accept edge.
REQ-022 Multiply SHALL form a 2*DATA_W-bit product; MUL returns the low half; MULH, MULHSU and MULHU return the high half with signed×signed, signed×unsigned and unsigned×unsigned interpretation respectively.
REQ-023 Divide SHALL round the quotient toward zero, and the remainder SHALL take the sign of the dividend.
REQ-024 Divide by zero: quotient all-ones, remainder = i_op_a.
REQ-025 Signed overflow (A = most negative, B = -1) for DIV/REM: quotient = A, remainder = 0.
REQ-026 DONE SHALL hold o_result and o_tag stable until i_valid-independent i_ready is high, then return to IDLE on that edge; a new accept SHALL not occur before the IDLE cycle (no back-to-back accept in the same cycle as the output handshake).
REQ-027 i_flush high at an edge in CALC or DONE SHALL force IDLE on that edge and drop o_valid with no result delivered; i_flush has priority over accept and output handshake.
REQ-028 o_result and o_tag SHALL be driven from registers only, never combinationally from inputs.

Reset
REQ-029 While i_areset_n is low, state SHALL be IDLE, o_valid 0, o_ready 1, o_busy 0, o_result 0, o_tag 0, and counter 0.
REQ-030 Reset asserted mid-operation SHALL discard the operation; the first accept after deassertion SHALL behave normally.

Configuration
REQ-031 Macro MDU_EARLY_OUT_EN: when defined, divide-by-zero, signed overflow, and any operation with a zero operand SHALL skip CALC, with o_valid rising 1 edge after accept and results identical to REQ-022..025.
REQ-032 Without MDU_EARLY_OUT_EN, every operation SHALL take the fixed latency of REQ-021.

Verification (DATA_W=32)
REQ-033 MUL A=0xFFFFFFFD (-3), B=7 -> o_result 0xFFFFFFEB, o_valid exactly 33 edges after accept; MULH A=B=0x80000000 -> 0x40000000.
REQ-034 DIV A=0xFFFFFFF9 (-7), B=2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU A=100, B=7 -> 14; REMU same operands -> 2.
REQ-035 DIV A=5, B=0 -> 0xFFFFFFFF; REM A=5, B=0 -> 5; DIV A=0x80000000, B=0xFFFFFFFF -> 0x80000000; REM same operands -> 0; with MDU_EARLY_OUT_EN each completes 1 edge after accept.
REQ-036 Result ready with i_ready held low 10 cycles -> o_valid, o_result and o_tag stable for all 10 cycles, o_ready 0; i_ready high -> IDLE next edge.
REQ-037 i_flush pulsed at CALC cycle 12 -> IDLE next edge, no o_valid; a following MULHU A=B=0xFFFFFFFF -> 0xFFFFFFFE.
REQ-038 i_areset_n low at CALC cycle 5 -> all outputs at REQ-029 values immediately; after release, DIVU 9/3 -> 3 with tag preserved.
